// File: rtl/bch_15_7_decoder.sv
// bch_15_7_decoder
//   Sequential bounded-distance decoder for the systematic binary BCH(15,7)
//   t=2 code over GF(16) (x^4+x+1, alpha=2, g(x)=x^8+x^7+x^6+x^4+1).
//   Flow: IDLE -> SYND (15) -> SOLVE (1) -> CHIEN (15) -> FINAL (1) -> DONE.
//   The FINAL cycle registers the result, so out_valid rises 32 cycles after
//   the accepting edge. When S1=0 and S3!=0, SOLVE jumps straight to FINAL,
//   which gives a latency of 17.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   input handshake; in_ready = idle & ~rst
//   in_codeword[14:0]   received word, bit k = coeff of x^k, [14:8] message
//   out_valid/out_ready output handshake; outputs held until accepted
//   out_message[6:0]    corrected message (raw bits [14:8] if uncorrectable)
//   out_err_count[1:0]  number of corrected bits
//   out_uncorrectable   decoding failure
//   out_err_mask[14:0]  flipped positions (only with BCH_DEC_ERR_MASK_EN)
//
// Optional feature macro: BCH_DEC_ERR_MASK_EN
module bch_15_7_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_codeword,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_message,
  output logic [1:0]  out_err_count,
  output logic        out_uncorrectable
`ifdef BCH_DEC_ERR_MASK_EN
  ,
  output logic [14:0] out_err_mask
`endif
);

  typedef enum logic [2:0] {IDLE, SYND, SOLVE, CHIEN, FINAL, DONE} state_t;

  // GF(16) multiply, shift-and-add with reduction by x^4+x+1.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
    end
    return p;
  endfunction

  // GF(16) inverse table; inv(0)=0 is a don't-care filler.
  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h1: r = 4'h1;  4'h2: r = 4'h9;  4'h3: r = 4'hE;  4'h4: r = 4'hD;
      4'h5: r = 4'hB;  4'h6: r = 4'h7;  4'h7: r = 4'h6;  4'h8: r = 4'hF;
      4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h5;  4'hC: r = 4'hA;
      4'hD: r = 4'h4;  4'hE: r = 4'h3;  4'hF: r = 4'h8;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  state_t      r_state;
  logic [14:0] r_cw;     // received word, corrected in place during CHIEN
  logic [3:0]  r_pos;    // bit position, 14 down to 0 in SYND and CHIEN
  logic [3:0]  r_s1;
  logic [3:0]  r_s3;
  logic [3:0]  r_t1;     // sigma1 * x term of the Chien evaluation
  logic [3:0]  r_t2;     // sigma2 * x^2 term
  logic [1:0]  r_deg;    // degree of sigma(x)
  logic [1:0]  r_roots;
  logic        r_unc;    // early-exit failure flag
`ifdef BCH_DEC_ERR_MASK_EN
  logic [14:0] r_fix;
`endif

  logic       w_bit;
  logic [3:0] w_s1_nxt;
  logic [3:0] w_s3_nxt;
  logic [3:0] w_s1_cu;
  logic [3:0] w_sig2;
  logic       w_root;
  logic       w_unc;

  assign in_ready = (r_state == IDLE) & ~rst;

  assign w_bit    = r_cw[r_pos];
  // Horner: after 15 steps S1 = r(alpha), S3 = r(alpha^3).
  assign w_s1_nxt = gf_mul(r_s1, 4'h2) ^ {3'b000, w_bit};
  assign w_s3_nxt = gf_mul(r_s3, 4'h8) ^ {3'b000, w_bit};
  assign w_s1_cu  = gf_mul(gf_mul(r_s1, r_s1), r_s1);
  // Evaluates to 0 when S3 = S1^3, which covers the single-error case.
  assign w_sig2   = gf_mul(r_s3 ^ w_s1_cu, gf_inv(r_s1));
  assign w_root   = ((4'h1 ^ r_t1 ^ r_t2) == 4'h0);
  assign w_unc    = r_unc | (r_roots != r_deg);

  // A root-count mismatch can only mean zero roots were found (a degree-2
  // sigma has 0 or 2 distinct roots, degree 1 always has 1), so on failure
  // nothing was flipped and r_cw still holds the received bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= IDLE;
      r_cw              <= '0;
      r_pos             <= '0;
      r_s1              <= '0;
      r_s3              <= '0;
      r_t1              <= '0;
      r_t2              <= '0;
      r_deg             <= '0;
      r_roots           <= '0;
      r_unc             <= 1'b0;
      out_valid         <= 1'b0;
      out_message       <= '0;
      out_err_count     <= '0;
      out_uncorrectable <= 1'b0;
`ifdef BCH_DEC_ERR_MASK_EN
      r_fix             <= '0;
      out_err_mask      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cw    <= in_codeword;
            r_pos   <= 4'd14;
            r_s1    <= '0;
            r_s3    <= '0;
            r_roots <= '0;
            r_unc   <= 1'b0;
`ifdef BCH_DEC_ERR_MASK_EN
            r_fix   <= '0;
`endif
            r_state <= SYND;
          end
        end
        SYND: begin
          r_s1 <= w_s1_nxt;
          r_s3 <= w_s3_nxt;
          if (r_pos == 4'd0) r_state <= SOLVE;
          else               r_pos   <= r_pos - 4'd1;
        end
        SOLVE: begin
          r_t1  <= gf_mul(r_s1, 4'h2);
          r_t2  <= gf_mul(w_sig2, 4'h4);
          r_deg <= (w_sig2 != 4'h0) ? 2'd2 : (r_s1 != 4'h0) ? 2'd1 : 2'd0;
          r_pos <= 4'd14;
          if (r_s1 == 4'h0 && r_s3 != 4'h0) begin
            r_unc   <= 1'b1;
            r_state <= FINAL;
          end else begin
            r_state <= CHIEN;
          end
        end
        CHIEN: begin
          if (w_root) begin
            r_cw[r_pos] <= ~r_cw[r_pos];
            r_roots     <= r_roots + 2'd1;
`ifdef BCH_DEC_ERR_MASK_EN
            r_fix[r_pos] <= 1'b1;
`endif
          end
          r_t1 <= gf_mul(r_t1, 4'h2);
          r_t2 <= gf_mul(r_t2, 4'h4);
          if (r_pos == 4'd0) r_state <= FINAL;
          else               r_pos   <= r_pos - 4'd1;
        end
        FINAL: begin
          out_valid         <= 1'b1;
          out_message       <= r_cw[14:8];
          out_err_count     <= w_unc ? 2'd0 : r_roots;
          out_uncorrectable <= w_unc;
`ifdef BCH_DEC_ERR_MASK_EN
          out_err_mask      <= w_unc ? 15'h0000 : r_fix;
`endif
          r_state           <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
